// File: rtl/cond_move_resolver.sv
// cond_move_resolver
// Two-stage resolver for MIPS conditional moves (MOVZ / MOVN).
// S1 captures the move and pre-computes "condition operand is zero" so the
// wide compare is finished one stage before the write decision is made.
// S2 holds the resolved move and drives the register-file write port.
// A saturating counter records moves dropped because their condition failed.
// Edge priority: Reset > Flush > Stall > normal advance.

module cond_move_resolver #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   InValid,
    input  logic                   MoveType,
    input  logic [DATA_WIDTH-1:0]  RsData,
    input  logic [DATA_WIDTH-1:0]  RtData,
    input  logic [4:0]             RdAddr,
    input  logic                   Stall,
    input  logic                   Flush,
    output logic                   OutValid,
    output logic                   RegWrite,
    output logic [DATA_WIDTH-1:0]  WriteData,
    output logic [4:0]             WriteAddr,
    output logic [COUNT_WIDTH-1:0] SquashCount
);

    // S1 registers
    logic                   r_v1;
    logic                   r_type1;
    logic                   r_z1;
    logic [DATA_WIDTH-1:0]  r_data1;
    logic [4:0]             r_addr1;

    // S2 registers
    logic                   r_v2;
    logic                   r_cond2;
    logic [DATA_WIDTH-1:0]  r_data2;
    logic [4:0]             r_addr2;

    logic [COUNT_WIDTH-1:0] r_squash;

    logic                   w_rt_zero;
    logic                   w_cond1;
    logic                   w_advance;
    logic                   w_squash_evt;
    logic                   w_squash_sat;

    // Reduction-NOR of the condition operand; registered as Z1.
    assign w_rt_zero    = ~|RtData;

    // MOVZ passes on zero, MOVN on non-zero.
    assign w_cond1      = r_type1 ? ~r_z1 : r_z1;

    // Pipeline moves only when neither flush nor stall is active.
    assign w_advance    = ~Flush & ~Stall;

    // A valid S1 entry with a failing condition is squashed as it enters S2.
    assign w_squash_evt = w_advance & r_v1 & ~w_cond1;
    assign w_squash_sat = &r_squash;

    // Stage 1: capture the incoming move, or drop it on flush / hold on stall.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_v1    <= 1'b0;
            r_type1 <= 1'b0;
            r_z1    <= 1'b0;
            r_data1 <= '0;
            r_addr1 <= 5'd0;
        end else if (Flush) begin
            r_v1    <= 1'b0;
        end else if (!Stall) begin
            r_v1    <= InValid;
            r_type1 <= MoveType;
            r_z1    <= w_rt_zero;
            r_data1 <= RsData;
            r_addr1 <= RdAddr;
        end
    end

    // Stage 2: resolve the condition and hold the move for the write port.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_v2    <= 1'b0;
            r_cond2 <= 1'b0;
            r_data2 <= '0;
            r_addr2 <= 5'd0;
        end else if (Flush) begin
            r_v2    <= 1'b0;
        end else if (!Stall) begin
            r_v2    <= r_v1;
            r_cond2 <= w_cond1;
            r_data2 <= r_data1;
            r_addr2 <= r_addr1;
        end
    end

    // Saturating squash counter; flushed or stalled entries never count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_squash <= '0;
        end else if (w_squash_evt && !w_squash_sat) begin
            r_squash <= r_squash + COUNT_WIDTH'(1);
        end
    end

    // Writes to $0 are suppressed but still reported as resolved via OutValid.
    assign OutValid    = r_v2;
    assign RegWrite    = r_v2 & r_cond2 & (r_addr2 != 5'd0);
    assign WriteData   = r_data2;
    assign WriteAddr   = r_addr2;
    assign SquashCount = r_squash;

endmodule

// File: doc/cond_move_resolver.md
# cond_move_resolver

Two-stage pipelined resolver for MIPS conditional moves (MOVZ/MOVN) in the execute/writeback path. It takes the move source, the condition register value and the destination address. It evaluates the zero/non-zero condition on the condition operand and emits a qualified register-file write (enable, data, address) two cycles later. It honours pipeline stall and flush, and keeps a saturating count of moves squashed because their condition failed.

## Interface
- DATA_WIDTH, 32, width of the move source and condition operands
- COUNT_WIDTH, 16, width of the squash counter
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- InValid  input  1  a move instruction is presented this cycle
- MoveType  input  1  0 = MOVZ (write if RtData == 0), 1 = MOVN (write if RtData != 0)
- RsData  input  DATA_WIDTH  value to be moved
- RtData  input  DATA_WIDTH  condition operand
- RdAddr  input  5  destination register
- Stall  input  1  hold both stages; ignore inputs
- Flush  input  1  invalidate both stages
- OutValid  output  1  output stage holds a resolved move
- RegWrite  output  1  qualified register-file write enable
- WriteData  output  DATA_WIDTH  data to write (RsData of the resolved move)
- WriteAddr  output  5  destination register of the resolved move
- SquashCount  output  COUNT_WIDTH  saturating count of condition-failed moves

## Operation
- Stage S1 registers on a capture edge:
  - V1 <= InValid
  - MoveType, RsData, RdAddr
  - Z1 <= (RtData == 0), a reduction-NOR of all DATA_WIDTH bits
- Stage S2 registers from S1 on an advance edge:
  - V2 <= V1
  - Cond2 <= MoveType ? !Z1 : Z1
  - data and address are copied through
- Outputs are driven from S2 only:
  - OutValid = V2
  - RegWrite = V2 & Cond2 & (WriteAddr != 0)
  - WriteData and WriteAddr come straight from S2 registers
- A write to $0 is always suppressed. It still counts as resolved and is not counted as squashed.
- SquashCount increments by 1 on each edge where S2 loads V1 = 1 with a failing condition. It saturates at all-ones and never wraps.
- Priority each edge: Reset > Flush > Stall > normal advance.
  - Flush: V1 and V2 are cleared. Data registers are don't-care. A concurrent InValid is dropped. SquashCount is unchanged by the flushed entries.
  - Stall (no Flush): all S1/S2 registers and SquashCount hold. Inputs are ignored, so upstream must hold the instruction.
  - Normal: S1 captures the inputs and S2 captures S1, in the same edge.
- Back-to-back moves are accepted every cycle when Stall is low.

## Timing
- Reset (asynchronous assert, released synchronously by the environment) clears:
  - V1, V2, Z1, Cond2
  - all data and address registers
  - SquashCount
  - so OutValid=0, RegWrite=0, WriteData=0, WriteAddr=0, SquashCount=0
- Latency: a move presented with InValid=1 before edge N, with no stall, appears on OutValid/RegWrite after edge N+1 (2 cycles).
- Each stall cycle adds one cycle of latency to in-flight entries. Outputs stay stable through the stall, so RegWrite may remain asserted. The consumer must qualify RegWrite with its own stall.
- Reset mid-operation: all in-flight moves are lost immediately. No write is issued after reset asserts.
- Throughput: 1 move per cycle, with no bubbles inserted by the block.

## Test plan
- Reset then idle: OutValid=0, RegWrite=0, WriteData=0, WriteAddr=0, SquashCount=0 held for 10 cycles.
- MOVZ, RsData=0xDEADBEEF, RtData=0, RdAddr=8 -> two cycles later RegWrite=1, WriteData=0xDEADBEEF, WriteAddr=8. Next cycle MOVZ with RtData=0x80000000 -> OutValid=1, RegWrite=0, SquashCount=1.
- MOVN back-to-back stream with RtData = 0, 1, 0xFFFFFFFF, RdAddr=0 on the last -> RegWrite = 0, 1, 0 on consecutive cycles. SquashCount ends at 1 (the $0 case is not counted).
- Stall for 3 cycles with a move in each stage -> outputs and SquashCount frozen. Release -> both moves retire in order with correct data.
- Flush asserted together with Stall and InValid while both stages are valid -> next cycle OutValid=0 and RegWrite=0. SquashCount unchanged. The dropped input never appears.
- With COUNT_WIDTH=4: 20 failing MOVZ -> SquashCount reaches 15 and stays 15. Reset asserted mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
